// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants and helpers for the LED-matrix scan timer.
//   CLK_HZ       system clock frequency
//   DEF_HALF_50M half-period divisor giving a 10 kHz scan clock from CLK_HZ
//   clog2()      ceiling log2, minimum 1, used to size row/blank counters
package matrix_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int SCAN_HZ      = 10_000;
    localparam int DEF_HALF_50M = CLK_HZ / (2 * SCAN_HZ) - 1;   // 2499

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/matrix_div_core.sv
// matrix_div_core: half-period counter and divided clock.
//   clk, rst   system clock, async active-low reset
//   en         advance the counter this cycle
//   clr        force count to 0 (divisor swap while frozen)
//   half       active half-period minus one
//   count      current position inside the half period
//   clk_out    divided clock (registered)
//   rise/fall  combinational strobes: clk_out toggles 0->1 / 1->0 at this edge
module matrix_div_core #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] half,
    output logic [DIV_W-1:0] count,
    output logic             clk_out,
    output logic             rise,
    output logic             fall
);

    logic at_end;

    assign at_end = en && (count == half);
    assign rise   = at_end && !clk_out;
    assign fall   = at_end &&  clk_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            clk_out <= 1'b0;
        end else if (clr) begin
            count   <= '0;
        end else if (en) begin
            if (at_end) begin
                count   <= '0;
                clk_out <= ~clk_out;
            end else begin
                count   <= count + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_scan_timer.sv
// matrix_scan_timer: programmable scan clock, row scanner and blanking for
// the LED-matrix driver.
//   clk, rst     50 MHz system clock, async active-low reset
//   en           run / freeze
//   div_half     new half-period minus one; div_load requests adoption
//   div_ack      pulse when the requested divisor takes effect
//   clk_out      50% duty scan clock
//   tick         pulse on the cycle clk_out rises
//   row_idx      current row, wraps ROWS-1 -> 0
//   frame_start  pulse with the tick that wraps row_idx to 0
//   blank        row-change blanking window
// Build option: define SCAN_BLANK_EN to build the blank counter; otherwise
// blank is constant 0.
module matrix_scan_timer
    import matrix_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int DEF_HALF     = DEF_HALF_50M,
    parameter int ROWS         = 8,
    parameter int ROW_W        = clog2(ROWS),
    parameter int BLANK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_half,
    input  logic             div_load,
    output logic             div_ack,
    output logic             clk_out,
    output logic             tick,
    output logic [ROW_W-1:0] row_idx,
    output logic             frame_start,
    output logic             blank
);

    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] pend_val;
    logic             pend_vld;
    logic [DIV_W-1:0] count;
    logic             rise, fall;
    logic             apply_run, apply_idle, apply;

    // A load arriving in the same cycle as a boundary supersedes the pending
    // value and waits for the following boundary, so only one ack is issued.
    assign apply_run  = fall && pend_vld && !div_load;
    assign apply_idle = !en && !clk_out && pend_vld && !div_load;
    assign apply      = apply_run || apply_idle;

    matrix_div_core #(.DIV_W(DIV_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (apply_idle),
        .half    (half),
        .count   (count),
        .clk_out (clk_out),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half     <= DIV_W'(DEF_HALF);
            pend_val <= '0;
            pend_vld <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            div_ack <= apply;
            if (apply) half <= pend_val;
            if (div_load) begin
                pend_val <= div_half;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick        <= 1'b0;
            frame_start <= 1'b0;
            row_idx     <= '0;
        end else begin
            tick        <= rise;
            frame_start <= rise && (row_idx == ROW_W'(ROWS - 1));
            if (rise) row_idx <= (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + ROW_W'(1);
        end
    end

`ifdef SCAN_BLANK_EN
    localparam int BW = clog2(BLANK_CYCLES + 1);
    logic [BW-1:0] blank_cnt;

    // Window opens the cycle after tick; the next rising edge cuts it short.
    // Runs on every clk cycle, independent of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank     <= 1'b0;
            blank_cnt <= '0;
        end else if (rise) begin
            blank     <= 1'b0;
            blank_cnt <= '0;
        end else if (tick) begin
            blank     <= 1'b1;
            blank_cnt <= BW'(BLANK_CYCLES - 1);
        end else if (blank) begin
            if (blank_cnt == '0) blank <= 1'b0;
            else                 blank_cnt <= blank_cnt - BW'(1);
        end
    end
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_scan_timer.sv
// tb_matrix_scan_timer: directed scenarios plus randomized en/load traffic,
// checked every cycle against a phase-position model of the scan timer,
// with literal expectations for periods, latencies and reset values.
// Define SCAN_BLANK_EN to match an RTL build with blanking enabled.
module tb_matrix_scan_timer;
    import matrix_pkg::*;

    localparam int DIV_W = 16;
    localparam int ROWS  = 8;
    localparam int ROW_W = 3;
    localparam int BLANK = 16;
    localparam int DEF   = 2499;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_half = '0;
    logic             div_ack, clk_out, tick, frame_start, blank;
    logic [ROW_W-1:0] row_idx;

    matrix_scan_timer #(
        .DIV_W(DIV_W), .DEF_HALF(DEF), .ROWS(ROWS), .ROW_W(ROW_W), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .div_half(div_half), .div_load(div_load),
        .div_ack(div_ack), .clk_out(clk_out), .tick(tick), .row_idx(row_idx),
        .frame_start(frame_start), .blank(blank)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---- model: position inside the scan period, pending divisor, row count
    int m_half = DEF, m_pos = 0, m_pval = 0, m_row = 0, m_cyc = 0, m_last = 0;
    bit m_pend = 0, m_tick = 0, m_fs = 0, m_ack = 0, m_have = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_half = DEF; m_pos = 0; m_pend = 0; m_pval = 0; m_row = 0;
            m_tick = 0; m_fs = 0; m_ack = 0; m_cyc = 0; m_have = 0; m_last = 0;
        end else begin
            bit ld, applied;
            int per;
            ld = div_load;
            applied = 0;
            per = 2 * (m_half + 1);
            m_tick = 0; m_fs = 0;
            m_cyc++;
            if (en) begin
                m_pos++;
                if (m_pos == m_half + 1) begin
                    m_tick = 1;
                    m_row = (m_row + 1) % ROWS;
                    m_fs = (m_row == 0);
                end
                if (m_pos == per) begin
                    m_pos = 0;
                    if (m_pend && !ld) begin m_half = m_pval; m_pend = 0; applied = 1; end
                end
            end else if (m_pos <= m_half && m_pend && !ld) begin
                m_half = m_pval; m_pos = 0; m_pend = 0; applied = 1;
            end
            if (ld) begin m_pend = 1; m_pval = int'(div_half); end
            m_ack = applied;
            if (m_tick) begin m_last = m_cyc; m_have = 1; end
        end
    end

    bit chk_on = 0;

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            bit exp_blank;
`ifdef SCAN_BLANK_EN
            exp_blank = !m_tick && m_have && (m_cyc - m_last) <= BLANK;
`else
            exp_blank = 0;
`endif
            check("clk_out",     {31'd0, clk_out},     {31'd0, m_pos > m_half});
            check("tick",        {31'd0, tick},        {31'd0, m_tick});
            check("row_idx",     {29'd0, row_idx},     m_row);
            check("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
            check("div_ack",     {31'd0, div_ack},     {31'd0, m_ack});
            check("blank",       {31'd0, blank},       {31'd0, exp_blank});
        end
    end

    // ---- stimulus-side observation (sampled 1 time unit after negedge)
    int cyc = 0, ntick = 0, last_tick = -1, last_int = 0, fs_tick = 0, nack = 0, last_ack = 0;

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
        if (tick === 1'b1) begin
            ntick++;
            if (last_tick >= 0) last_int = cyc - last_tick;
            last_tick = cyc;
            if (frame_start === 1'b1) fs_tick = ntick;
        end
        if (div_ack === 1'b1) begin nack++; last_ack = cyc; end
    endtask

    task automatic wait_ticks(input int n, input int budget, input string nm);
        int target, b;
        target = ntick + n;
        b = 0;
        while (ntick < target && b < budget) begin step(); b++; end
        check(nm, ntick, target);
    endtask

    task automatic measure(input int n, output int mn, output int mx);
        int run;
        logic prev;
        bit started;
        run = 0; prev = clk_out; started = 0; mn = 1000000; mx = 0;
        repeat (n) begin
            step();
            if (clk_out === prev) run++;
            else begin
                if (started) begin
                    if (run < mn) mn = run;
                    if (run > mx) mx = run;
                end
                started = 1; run = 1; prev = clk_out;
            end
        end
    endtask

    initial begin
        int start, na0, nt0, k, mn, mx;
        step(); step();
        chk_on = 1;
        step();
        check("rst_clk_out", {31'd0, clk_out}, 0);
        check("rst_row", {29'd0, row_idx}, 0);

        // 1: default divisor, eight ticks, frame wrap
        rst = 1'b1; en = 1'b1; start = cyc;
        wait_ticks(1, 3000, "t1_first_tick");
        check("t1_first_lat", last_tick - start, 2500);
        check("t1_row1", {29'd0, row_idx}, 1);
        wait_ticks(7, 40000, "t1_eight_ticks");
        check("t1_period", last_int, 5000);
        check("t1_fs_tick", fs_tick, 8);
        check("t1_row_wrap", {29'd0, row_idx}, 0);

        // 2: load 4 in the high phase; current period completes
        repeat (100) step();
        div_half = 16'd4; div_load = 1'b1;
        step();
        div_load = 1'b0;
        na0 = nack; k = 0;
        while (nack == na0 && k < 3000) begin step(); k++; end
        check("t2_ack_seen", nack - na0, 1);
        check("t2_ack_at_fall", last_ack - last_tick, 2500);
        wait_ticks(1, 50, "t2_tick");
        step();
`ifdef SCAN_BLANK_EN
        check("t2_blank_after_tick", {31'd0, blank}, 1);
`else
        check("t2_blank_after_tick", {31'd0, blank}, 0);
`endif
        measure(60, mn, mx);
        check("t2_min_phase", mn, 5);
        check("t2_max_phase", mx, 5);
        wait_ticks(2, 50, "t2_ticks");
        check("t2_period", last_int, 10);

        // 3: two loads before one boundary
        step(); step();
        div_half = 16'd9; div_load = 1'b1; step();
        div_half = 16'd2; step();
        div_load = 1'b0;
        na0 = nack;
        repeat (30) step();
        check("t3_single_ack", nack - na0, 1);
        wait_ticks(2, 50, "t3_ticks");
        check("t3_period", last_int, 6);

        // 4: freeze mid-high-phase for 100 cycles
        wait_ticks(1, 20, "t4_tick");
        step(); step();
        check("t4_high_before", {31'd0, clk_out}, 1);
        en = 1'b0; nt0 = ntick;
        repeat (100) step();
        check("t4_no_ticks", ntick - nt0, 0);
        check("t4_held_high", {31'd0, clk_out}, 1);
        en = 1'b1; nt0 = ntick; k = 0;
        while (ntick == nt0 && k < 20) begin step(); k++; end
        check("t4_resume_lat", k, 4);

        // 5: reset at row 5 with a load pending
        k = 0;
        while (row_idx !== 3'd5 && k < 100) begin step(); k++; end
        check("t5_row5", {29'd0, row_idx}, 5);
        div_half = 16'd7; div_load = 1'b1;
        step();
        div_load = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t5_async_clk_out", {31'd0, clk_out}, 0);
        check("t5_async_row", {29'd0, row_idx}, 0);
        check("t5_async_tick", {31'd0, tick}, 0);
        check("t5_async_fs", {31'd0, frame_start}, 0);
        check("t5_async_ack", {31'd0, div_ack}, 0);
        check("t5_async_blank", {31'd0, blank}, 0);
        step(); step();
        rst = 1'b1; start = cyc; na0 = nack; last_tick = -1;
        wait_ticks(1, 3000, "t5_first_tick");
        check("t5_first_lat", last_tick - start, 2500);
        wait_ticks(1, 6000, "t5_second_tick");
        check("t5_period", last_int, 5000);
        check("t5_no_ack", nack - na0, 0);
        check("t5_row", {29'd0, row_idx}, 2);

        // random en / load traffic, small divisors including 0
        div_half = 16'd1; div_load = 1'b1; step(); div_load = 1'b0;
        repeat (6000) step();
        repeat (3000) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                div_load = 1'b1;
                div_half = 16'($urandom_range(0, 5));
            end else begin
                div_load = 1'b0;
            end
            step();
        end
        en = 1'b1; div_load = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
